// File: rtl/pcc_receive_data.sv
// PCC destination endpoint: accepts head/body/tail flits, returns pack/fail/cancel
// pulses, and keeps per-packet sequence, length, checksum and latency statistics.
module pcc_receive_data #(
    parameter logic [7:0]  MY_ID          = 8'h00,
    parameter int unsigned CHECK_ID       = 1,
    parameter int unsigned PACK_NUM       = 1,
    parameter int unsigned ACK_DELAY      = 4,
    parameter int unsigned CANCEL_DELAY   = 2,
    parameter logic [15:0] PACKAGE_LENGTH = 16'd128,
    parameter logic [15:0] TIMEOUT        = 16'd1024,
    parameter int unsigned DATAW          = 66
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DATAW-1:0] PCC_ip_data_i,
    input  logic             PCC_ip_stb_i,
    input  logic             PCC_ip_fwd_i,
    output logic             PCC_ip_pack_o,
    output logic             PCC_ip_fail_o,
    output logic             PCC_ip_cancel_o,
    output logic [15:0]      pkt_cnt_o,
    output logic [15:0]      err_cnt_o,
    output logic [15:0]      flit_cnt_o,
    output logic             seq_err_o,
    output logic             len_err_o,
    output logic [31:0]      csum_o,
    output logic [31:0]      last_lat_o
);

    localparam int unsigned ACK_FIRST   = ACK_DELAY - 1;
    localparam int unsigned ACK_LAST    = ACK_FIRST + 2 * (PACK_NUM - 1);
    localparam logic [15:0] ACK_FIRST_W = 16'(ACK_FIRST);
    localparam logic [15:0] ACK_LAST_W  = 16'(ACK_LAST);
    localparam logic        ACK_PAR     = 1'(ACK_FIRST % 2);
    localparam logic [15:0] CLOSE_LAST  = 16'(CANCEL_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_RECV  = 2'd2,
        S_CLOSE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_stb_q;
    logic [1:0]  r_type_q;
    logic [15:0] r_idx_q;
    logic        r_first_body;
    logic [15:0] r_cnt;
    logic [31:0] r_lat;

    logic [1:0]  w_type;
    logic [15:0] w_idx;
    logic [31:0] w_payload;
    logic        w_head;
    logic        w_body;
    logic        w_tail;
    logic        w_stb_fall;
    logic        w_id_ok;
    logic        w_timeout;
    logic        w_unused;

    assign w_type     = PCC_ip_data_i[65:64];
    assign w_idx      = PCC_ip_data_i[63:48];
    assign w_payload  = PCC_ip_data_i[31:0];
    assign w_unused   = ^PCC_ip_data_i[47:32];

    assign w_head     = PCC_ip_stb_i & ~r_stb_q & (w_type == 2'b10);
    // Sender holds data between beats, so only a new index (or the first body) counts.
    assign w_body     = (w_type == 2'b00) & PCC_ip_fwd_i & (r_first_body | (w_idx != r_idx_q));
    assign w_tail     = (w_type == 2'b01) & (r_type_q != 2'b01);
    assign w_stb_fall = r_stb_q & ~PCC_ip_stb_i;
    assign w_id_ok    = (CHECK_ID == 0) || (PCC_ip_data_i[7:0] == MY_ID);
    assign w_timeout  = (r_cnt + 16'd1) == TIMEOUT;

    // r_cnt is the ACK/CLOSE delay counter and the RECV idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_stb_q         <= 1'b0;
            r_type_q        <= 2'b00;
            r_idx_q         <= 16'd0;
            r_first_body    <= 1'b0;
            r_cnt           <= 16'd0;
            r_lat           <= 32'd0;
            PCC_ip_pack_o   <= 1'b0;
            PCC_ip_fail_o   <= 1'b0;
            PCC_ip_cancel_o <= 1'b0;
            pkt_cnt_o       <= 16'd0;
            err_cnt_o       <= 16'd0;
            flit_cnt_o      <= 16'd0;
            seq_err_o       <= 1'b0;
            len_err_o       <= 1'b0;
            csum_o          <= 32'd0;
            last_lat_o      <= 32'd0;
        end else begin
            r_stb_q         <= PCC_ip_stb_i;
            r_type_q        <= w_type;
            r_idx_q         <= w_idx;
            PCC_ip_pack_o   <= 1'b0;
            PCC_ip_fail_o   <= 1'b0;
            PCC_ip_cancel_o <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_head) begin
                        if (w_id_ok) begin
                            flit_cnt_o   <= 16'd0;
                            csum_o       <= 32'd0;
                            seq_err_o    <= 1'b0;
                            len_err_o    <= 1'b0;
                            r_lat        <= 32'd0;
                            r_first_body <= 1'b1;
                            r_cnt        <= 16'd0;
                            r_state      <= S_ACK;
                        end else begin
                            PCC_ip_fail_o <= 1'b1;
                            err_cnt_o     <= err_cnt_o + 16'd1;
                        end
                    end
                end

                S_ACK: begin
                    r_lat <= r_lat + 32'd1;
                    r_cnt <= r_cnt + 16'd1;
                    if (w_body) begin
                        seq_err_o <= 1'b1;
                    end
                    if (w_stb_fall) begin
                        err_cnt_o <= err_cnt_o + 16'd1;
                        r_state   <= S_IDLE;
                    end else if ((r_cnt >= ACK_FIRST_W) && (r_cnt[0] == ACK_PAR)) begin
                        // Pulses sit on every other count once the initial delay has elapsed.
                        PCC_ip_pack_o <= 1'b1;
                        if (r_cnt == ACK_LAST_W) begin
                            r_cnt   <= 16'd1;
                            r_state <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    r_lat <= r_lat + 32'd1;
                    if (w_tail) begin
                        len_err_o  <= (flit_cnt_o != PACKAGE_LENGTH);
                        last_lat_o <= r_lat + 32'd1;
                        r_cnt      <= 16'd0;
                        r_state    <= S_CLOSE;
                    end else if (w_stb_fall) begin
                        err_cnt_o <= err_cnt_o + 16'd1;
                        r_state   <= S_IDLE;
                    end else if (w_body) begin
                        if (flit_cnt_o != 16'hFFFF) begin
                            flit_cnt_o <= flit_cnt_o + 16'd1;
                        end
                        csum_o <= csum_o ^ w_payload;
                        if (w_idx != flit_cnt_o) begin
                            seq_err_o <= 1'b1;
                        end
                        r_first_body <= 1'b0;
                        r_cnt        <= 16'd1;
                    end else if (w_timeout) begin
                        PCC_ip_fail_o <= 1'b1;
                        err_cnt_o     <= err_cnt_o + 16'd1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_CLOSE: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == CLOSE_LAST) begin
                        PCC_ip_cancel_o <= 1'b1;
                        if (!seq_err_o && !len_err_o) begin
                            pkt_cnt_o <= pkt_cnt_o + 16'd1;
                        end else begin
                            err_cnt_o <= err_cnt_o + 16'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcc_receive_data.sv
// Bench for pcc_receive_data: two instances (PACK_NUM 1 and 3) on shared stimulus,
// random payloads and gaps, expectations from a packet-level model.
module tb_pcc_receive_data;

    logic        clk = 1'b0;
    logic        reset;
    logic [65:0] data;
    logic        stb;
    logic        fwd;

    logic        a_pack, a_fail, a_cancel, a_seq, a_len;
    logic [15:0] a_pkt, a_err, a_flit;
    logic [31:0] a_csum, a_lat;
    logic        b_pack, b_fail, b_cancel, b_seq, b_len;
    logic [15:0] b_pkt, b_err, b_flit;
    logic [31:0] b_csum, b_lat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlaps = 0;

    int packA_q[$], packB_q[$], failA_q[$], failB_q[$], cancelA_q[$];

    int          h, t, bl;
    int          exp_pkt = 0, exp_err = 0;
    logic [15:0] m_flit;
    logic [31:0] m_csum;
    logic        m_seq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pcc_receive_data #(.PACK_NUM(1), .TIMEOUT(16'd16)) u_dut_a (
        .clk(clk), .reset(reset), .PCC_ip_data_i(data), .PCC_ip_stb_i(stb), .PCC_ip_fwd_i(fwd),
        .PCC_ip_pack_o(a_pack), .PCC_ip_fail_o(a_fail), .PCC_ip_cancel_o(a_cancel),
        .pkt_cnt_o(a_pkt), .err_cnt_o(a_err), .flit_cnt_o(a_flit), .seq_err_o(a_seq),
        .len_err_o(a_len), .csum_o(a_csum), .last_lat_o(a_lat)
    );

    pcc_receive_data #(.PACK_NUM(3), .TIMEOUT(16'd16)) u_dut_b (
        .clk(clk), .reset(reset), .PCC_ip_data_i(data), .PCC_ip_stb_i(stb), .PCC_ip_fwd_i(fwd),
        .PCC_ip_pack_o(b_pack), .PCC_ip_fail_o(b_fail), .PCC_ip_cancel_o(b_cancel),
        .pkt_cnt_o(b_pkt), .err_cnt_o(b_err), .flit_cnt_o(b_flit), .seq_err_o(b_seq),
        .len_err_o(b_len), .csum_o(b_csum), .last_lat_o(b_lat)
    );

    // Pulse recorder: cycle numbers of every pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_pack === 1'b1)   packA_q.push_back(cyc);
        if (b_pack === 1'b1)   packB_q.push_back(cyc);
        if (a_fail === 1'b1)   failA_q.push_back(cyc);
        if (b_fail === 1'b1)   failB_q.push_back(cyc);
        if (a_cancel === 1'b1) cancelA_q.push_back(cyc);
        if ((int'(a_pack === 1'b1) + int'(a_fail === 1'b1) + int'(a_cancel === 1'b1)) > 1)
            overlaps++;
        if ((int'(b_pack === 1'b1) + int'(b_fail === 1'b1) + int'(b_cancel === 1'b1)) > 1)
            overlaps++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int q[$], input int e[$]);
        chk({tag, "_n"}, 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            chk({tag, "_t"}, (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(e[i]));
    endtask

    task automatic clr_q();
        packA_q.delete(); packB_q.delete(); failA_q.delete();
        failB_q.delete(); cancelA_q.delete();
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_pktA"}, 32'(a_pkt), 32'(exp_pkt));
        chk({tag, "_errA"}, 32'(a_err), 32'(exp_err));
        chk({tag, "_pktB"}, 32'(b_pkt), 32'(exp_pkt));
        chk({tag, "_errB"}, 32'(b_err), 32'(exp_err));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pulsesA"}, 32'({a_pack, a_fail, a_cancel}), 32'd0);
        chk({tag, "_pulsesB"}, 32'({b_pack, b_fail, b_cancel}), 32'd0);
        chk({tag, "_pkt"},  32'(a_pkt),  32'd0);
        chk({tag, "_err"},  32'(a_err),  32'd0);
        chk({tag, "_flit"}, 32'(a_flit), 32'd0);
        chk({tag, "_seq"},  32'(a_seq),  32'd0);
        chk({tag, "_len"},  32'(a_len),  32'd0);
        chk({tag, "_csum"}, a_csum,      32'd0);
        chk({tag, "_lat"},  a_lat,       32'd0);
        chk({tag, "_B"},    32'(b_pkt) | 32'(b_err) | 32'(b_flit) | b_csum | b_lat, 32'd0);
    endtask

    task automatic send_head(input logic [7:0] id);
        logic [63:0] r;
        r    = {$urandom, $urandom};
        stb  = 1'b1;
        fwd  = 1'b0;
        data = {2'b10, r[55:0], id};
        h    = cyc;
        step();
    endtask

    // One body beat, then `gap` held cycles (fwd forced high or random).
    task automatic send_body(input logic [15:0] idx, input int gap, input bit hold_fwd);
        logic [31:0] pl;
        pl     = $urandom;
        data   = {2'b00, idx, 16'($urandom), pl};
        fwd    = 1'b1;
        bl     = cyc;
        m_csum = m_csum ^ pl;
        m_flit = m_flit + 16'd1;
        step();
        for (int g = 0; g < gap; g++) begin
            fwd = hold_fwd ? 1'b1 : 1'($urandom);
            step();
        end
    endtask

    task automatic send_tail();
        logic [63:0] r;
        r    = {$urandom, $urandom};
        data = {2'b01, r};
        fwd  = 1'b0;
        t    = cyc;
        step();
        step();
        stb  = 1'b0;
        data = '0;
        repeat (6) step();
    endtask

    // Full packet of n bodies; skip makes indices 0,1,3,4,...
    task automatic run_packet(input string tag, input int n, input bit skip);
        int          e[$];
        logic [15:0] idx;
        logic        lenerr;
        send_head(8'h00);
        repeat (12) step();
        m_flit = 16'd0; m_csum = 32'd0; m_seq = 1'b0;
        for (int k = 0; k < n; k++) begin
            idx = 16'((skip && k >= 2) ? k + 1 : k);
            if (idx != 16'(k)) m_seq = 1'b1;
            send_body(idx, (k == 3) ? 3 : $urandom_range(0, 2), k == 3);
        end
        send_tail();
        lenerr = (n != 128);
        if (!m_seq && !lenerr) exp_pkt++;
        else exp_err++;
        e = {}; e.push_back(h + 5);
        chk_q({tag, "_packA"}, packA_q, e);
        e.push_back(h + 7); e.push_back(h + 9);
        chk_q({tag, "_packB"}, packB_q, e);
        e = {}; e.push_back(t + 3);
        chk_q({tag, "_cancel"}, cancelA_q, e);
        e = {};
        chk_q({tag, "_fail"}, failA_q, e);
        chk({tag, "_flit"}, 32'(a_flit), 32'(m_flit));
        chk({tag, "_csum"}, a_csum, m_csum);
        chk({tag, "_seq"},  32'(a_seq), 32'(m_seq));
        chk({tag, "_len"},  32'(a_len), 32'(lenerr));
        chk({tag, "_lat"},  a_lat, 32'(t - h));
        chk({tag, "_csumB"}, b_csum, m_csum);
        chk_counts(tag);
        clr_q();
    endtask

    initial begin
        int e[$];
        reset = 1'b1;
        data  = '0;
        stb   = 1'b0;
        fwd   = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        reset = 1'b0;
        step();
        clr_q();

        run_packet("good1", 128, 1'b0);

        // ID mismatch: fail one cycle after the head, no pack.
        send_head(8'h05);
        step();
        stb = 1'b0;
        repeat (4) step();
        exp_err++;
        e = {}; e.push_back(h + 1);
        chk_q("badid_fail", failA_q, e);
        e = {};
        chk_q("badid_pack", packA_q, e);
        chk_counts("badid");
        clr_q();

        run_packet("seqerr", 128, 1'b1);
        run_packet("short", 10, 1'b0);

        // Idle timeout after body index 10.
        send_head(8'h00);
        repeat (12) step();
        m_flit = 16'd0; m_csum = 32'd0;
        for (int k = 0; k <= 10; k++) send_body(16'(k), 0, 1'b0);
        fwd = 1'b0;
        repeat (20) step();
        stb  = 1'b0;
        data = '0;
        repeat (3) step();
        exp_err++;
        e = {}; e.push_back(bl + 16);
        chk_q("tmo_failA", failA_q, e);
        chk_q("tmo_failB", failB_q, e);
        e = {};
        chk_q("tmo_cancel", cancelA_q, e);
        chk("tmo_flit", 32'(a_flit), 32'(m_flit));
        chk("tmo_csum", a_csum, m_csum);
        chk_counts("tmo");
        clr_q();

        run_packet("good2", 128, 1'b0);

        // Sender abort: strobe drops in RECV.
        send_head(8'h00);
        repeat (12) step();
        for (int k = 0; k < 5; k++) send_body(16'(k), 1, 1'b0);
        stb = 1'b0;
        fwd = 1'b0;
        repeat (5) step();
        exp_err++;
        e = {};
        chk_q("abort_fail", failA_q, e);
        chk_q("abort_cancel", cancelA_q, e);
        chk_counts("abort");
        clr_q();

        // Reset in RECV clears everything; a later tail is ignored.
        send_head(8'h00);
        repeat (12) step();
        for (int k = 0; k < 5; k++) send_body(16'(k), 0, 1'b0);
        e = {}; e.push_back(h + 5); e.push_back(h + 7); e.push_back(h + 9);
        chk_q("pk3_packB", packB_q, e);
        reset = 1'b1;
        step();
        chk_zero("midrst");
        reset = 1'b0;
        clr_q();
        exp_pkt = 0;
        exp_err = 0;
        send_tail();
        e = {};
        chk_q("postrst_cancel", cancelA_q, e);
        chk_q("postrst_fail", failA_q, e);
        chk_counts("postrst");

        chk("overlap", 32'(overlaps), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
